// File: rtl/vcve2_vec_ex_sequencer.sv
// Vector EX-interface initiator: walks a vector op word by word through VRF read, EX, VRF write.
// Optional build macro VCVE2_VEC_SEQ_KILL_EN adds kill_i to abandon an op in flight.

package vcve2_vec_seq_pkg;
  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4,
    ALU_SRA = 7'd5,
    ALU_SRL = 7'd6,
    ALU_SLL = 7'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;
endpackage

module vcve2_vec_ex_sequencer
  import vcve2_vec_seq_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  localparam int unsigned NW  = VLEN / 32,
  localparam int unsigned WW  = $clog2(NW),
  localparam int unsigned VLW = $clog2(VLEN / 8) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [VLW-1:0] req_vl_i,
  input  logic [2:0]     req_vsew_i,
  input  logic [4:0]     req_vs1_i,
  input  logic [4:0]     req_vs2_i,
  input  logic [4:0]     req_vd_i,
  input  alu_op_e        req_alu_op_i,
  input  logic           req_mult_i,
  input  md_op_e         req_md_op_i,
  output logic [4:0]     vrf_rreg_a_o,
  output logic [4:0]     vrf_rreg_b_o,
  output logic [4:0]     vrf_rreg_c_o,
  output logic [WW-1:0]  vrf_rword_o,
  input  logic [31:0]    vrf_rdata_a_i,
  input  logic [31:0]    vrf_rdata_b_i,
  input  logic [31:0]    vrf_rdata_c_i,
  output alu_op_e        ex_alu_operator_o,
  output logic [31:0]    ex_operand_a_o,
  output logic [31:0]    ex_operand_b_o,
  output logic [31:0]    ex_operand_c_o,
  output logic           ex_instr_first_cycle_o,
  output logic           ex_mult_en_o,
  output logic           ex_mult_sel_o,
  output md_op_e         ex_md_op_o,
  output logic           ex_vec_instr_o,
  output logic [2:0]     ex_vsew_o,
  input  logic [31:0]    ex_result_i,
  input  logic           ex_valid_i,
  output logic           vrf_we_o,
  output logic [4:0]     vrf_wreg_o,
  output logic [WW-1:0]  vrf_wword_o,
  output logic [3:0]     vrf_wbe_o,
  output logic [31:0]    vrf_wdata_o,
`ifdef VCVE2_VEC_SEQ_KILL_EN
  input  logic           kill_i,
`endif
  output logic           done_o,
  output logic           err_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_e;

  localparam logic [VLW-1:0] VL_MAX = VLW'(VLEN / 8);

  state_e          state_q, state_n;
  logic [VLW-1:0]  vl_sat;
  logic [VLW+1:0]  bytes_c, words_c;
  logic [WW-1:0]   last_c;
  logic            sew_legal;
  logic            kill;

  logic [4:0]      vs1_q, vs2_q, vd_q;
  logic [2:0]      vsew_q;
  alu_op_e         alu_op_q;
  md_op_e          md_op_q;
  logic            mult_q;
  logic            err_q;
  logic [WW-1:0]   word_idx_q, last_q;
  logic [1:0]      rem_q;
  logic [31:0]     opa_q, opb_q, opc_q, result_q;
  logic            first_q;

`ifdef VCVE2_VEC_SEQ_KILL_EN
  assign kill = kill_i;
`else
  assign kill = 1'b0;
`endif

  // An op longer than one register at wide SEW is clamped to the register.
  always_comb begin
    vl_sat    = (req_vl_i > VL_MAX) ? VL_MAX : req_vl_i;
    sew_legal = (req_vsew_i <= 3'd2);
    bytes_c   = (VLW+2)'(vl_sat) << req_vsew_i[1:0];
    words_c   = (bytes_c + (VLW+2)'(3)) >> 2;
    if (words_c > (VLW+2)'(NW)) last_c = WW'(NW - 1);
    else                        last_c = WW'(words_c - (VLW+2)'(1));
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (req_valid_i) state_n = (!sew_legal || vl_sat == '0) ? S_DONE : S_READ;
      S_READ:  state_n = S_EXEC;
      S_EXEC:  if (ex_valid_i) state_n = S_WRITE;
      S_WRITE: state_n = (word_idx_q == last_q) ? S_DONE : S_READ;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill && state_q != S_IDLE) state_n = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      vsew_q     <= '0;
      alu_op_q   <= ALU_ADD;
      md_op_q    <= MD_OP_MULL;
      mult_q     <= 1'b0;
      err_q      <= 1'b0;
      word_idx_q <= '0;
      last_q     <= '0;
      rem_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      opc_q      <= '0;
      result_q   <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == S_IDLE && req_valid_i) begin
        vs1_q      <= req_vs1_i;
        vs2_q      <= req_vs2_i;
        vd_q       <= req_vd_i;
        vsew_q     <= req_vsew_i;
        alu_op_q   <= req_alu_op_i;
        md_op_q    <= req_md_op_i;
        mult_q     <= req_mult_i;
        err_q      <= !sew_legal;
        word_idx_q <= '0;
        last_q     <= last_c;
        rem_q      <= bytes_c[1:0];
      end
      // Read data is captured at the edge that ends READ; operand a is vs2, b is vs1.
      if (state_q == S_READ) begin
        opa_q   <= vrf_rdata_b_i;
        opb_q   <= vrf_rdata_a_i;
        opc_q   <= vrf_rdata_c_i;
        first_q <= 1'b1;
      end
      if (state_q == S_EXEC) begin
        first_q <= 1'b0;
        if (ex_valid_i) result_q <= ex_result_i;
      end
      if (state_q == S_WRITE) word_idx_q <= word_idx_q + WW'(1);
    end
  end

  always_comb begin
    req_ready_o            = (state_q == S_IDLE);
    vrf_rreg_a_o           = '0;
    vrf_rreg_b_o           = '0;
    vrf_rreg_c_o           = '0;
    vrf_rword_o            = '0;
    ex_alu_operator_o      = ALU_ADD;
    ex_operand_a_o         = '0;
    ex_operand_b_o         = '0;
    ex_operand_c_o         = '0;
    ex_instr_first_cycle_o = 1'b0;
    ex_mult_en_o           = 1'b0;
    ex_mult_sel_o          = 1'b0;
    ex_md_op_o             = MD_OP_MULL;
    ex_vec_instr_o         = 1'b0;
    ex_vsew_o              = '0;
    vrf_we_o               = 1'b0;
    vrf_wreg_o             = '0;
    vrf_wword_o            = '0;
    vrf_wbe_o              = '0;
    vrf_wdata_o            = '0;
    done_o                 = 1'b0;
    err_o                  = 1'b0;
    case (state_q)
      S_READ: begin
        vrf_rreg_a_o = vs1_q;
        vrf_rreg_b_o = vs2_q;
        vrf_rreg_c_o = vd_q;
        vrf_rword_o  = word_idx_q;
      end
      S_EXEC: begin
        ex_alu_operator_o      = alu_op_q;
        ex_operand_a_o         = opa_q;
        ex_operand_b_o         = opb_q;
        ex_operand_c_o         = opc_q;
        ex_instr_first_cycle_o = first_q;
        ex_mult_en_o           = mult_q;
        ex_mult_sel_o          = mult_q;
        ex_md_op_o             = md_op_q;
        ex_vec_instr_o         = 1'b1;
        ex_vsew_o              = vsew_q;
      end
      S_WRITE: begin
        vrf_we_o    = !kill;
        vrf_wreg_o  = vd_q;
        vrf_wword_o = word_idx_q;
        vrf_wdata_o = result_q;
        if (word_idx_q == last_q && rem_q != 2'd0) vrf_wbe_o = 4'((4'd1 << rem_q) - 4'd1);
        else                                       vrf_wbe_o = 4'hF;
      end
      S_DONE: begin
        done_o = !kill;
        err_o  = !kill && err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vcve2_vec_ex_sequencer.sv
// Directed bench for vcve2_vec_ex_sequencer: VRF model, EX stub with programmable stall, vector table.
module tb_vcve2_vec_ex_sequencer;
  import vcve2_vec_seq_pkg::*;

  localparam int VLEN = 256;
  localparam int NW   = 8;
  localparam int WW   = 3;
  localparam int VLW  = 6;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           req_valid;
  logic           req_ready_o;
  logic [VLW-1:0] req_vl;
  logic [2:0]     req_vsew;
  logic [4:0]     req_vs1, req_vs2, req_vd;
  alu_op_e        req_alu_op;
  logic           req_mult;
  md_op_e         req_md_op;
  logic [4:0]     vrf_rreg_a_o, vrf_rreg_b_o, vrf_rreg_c_o;
  logic [WW-1:0]  vrf_rword_o;
  logic [31:0]    vrf_rdata_a, vrf_rdata_b, vrf_rdata_c;
  alu_op_e        ex_alu_operator_o;
  logic [31:0]    ex_operand_a_o, ex_operand_b_o, ex_operand_c_o;
  logic           ex_instr_first_cycle_o, ex_mult_en_o, ex_mult_sel_o;
  md_op_e         ex_md_op_o;
  logic           ex_vec_instr_o;
  logic [2:0]     ex_vsew_o;
  logic [31:0]    ex_result;
  logic           ex_valid;
  logic           vrf_we_o;
  logic [4:0]     vrf_wreg_o;
  logic [WW-1:0]  vrf_wword_o;
  logic [3:0]     vrf_wbe_o;
  logic [31:0]    vrf_wdata_o;
  logic           done_o, err_o;
`ifdef VCVE2_VEC_SEQ_KILL_EN
  logic           kill_i = 1'b0;
`endif

  vcve2_vec_ex_sequencer #(.VLEN(VLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_vl_i(req_vl), .req_vsew_i(req_vsew),
    .req_vs1_i(req_vs1), .req_vs2_i(req_vs2), .req_vd_i(req_vd),
    .req_alu_op_i(req_alu_op), .req_mult_i(req_mult), .req_md_op_i(req_md_op),
    .vrf_rreg_a_o(vrf_rreg_a_o), .vrf_rreg_b_o(vrf_rreg_b_o), .vrf_rreg_c_o(vrf_rreg_c_o),
    .vrf_rword_o(vrf_rword_o),
    .vrf_rdata_a_i(vrf_rdata_a), .vrf_rdata_b_i(vrf_rdata_b), .vrf_rdata_c_i(vrf_rdata_c),
    .ex_alu_operator_o(ex_alu_operator_o),
    .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o), .ex_operand_c_o(ex_operand_c_o),
    .ex_instr_first_cycle_o(ex_instr_first_cycle_o),
    .ex_mult_en_o(ex_mult_en_o), .ex_mult_sel_o(ex_mult_sel_o),
    .ex_md_op_o(ex_md_op_o), .ex_vec_instr_o(ex_vec_instr_o), .ex_vsew_o(ex_vsew_o),
    .ex_result_i(ex_result), .ex_valid_i(ex_valid),
    .vrf_we_o(vrf_we_o), .vrf_wreg_o(vrf_wreg_o), .vrf_wword_o(vrf_wword_o),
    .vrf_wbe_o(vrf_wbe_o), .vrf_wdata_o(vrf_wdata_o),
`ifdef VCVE2_VEC_SEQ_KILL_EN
    .kill_i(kill_i),
`endif
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [32][NW];
  logic [31:0] orig [32][NW];

  assign vrf_rdata_a = mem[vrf_rreg_a_o][vrf_rword_o];
  assign vrf_rdata_b = mem[vrf_rreg_b_o][vrf_rword_o];
  assign vrf_rdata_c = mem[vrf_rreg_c_o][vrf_rword_o];

  typedef struct {
    logic [VLW-1:0] vl;
    logic [2:0]     vsew;
    logic [4:0]     vs1, vs2, vd;
    logic           mult;
    int             stall;
    logic           noise;
    int             nw;
    logic [3:0]     lwbe;
    logic           err;
    int             lat;
  } vec_t;

  vec_t tbl [11];

  int checks = 0, failures = 0;

  logic [4:0]  cur_vs1, cur_vs2, cur_vd;
  logic        cur_mult, cur_noise;
  logic [2:0]  cur_vsew;
  alu_op_e     cur_alu;
  md_op_e      cur_md;
  int          cur_stall, cur_nw;
  logic [3:0]  cur_lwbe;
  int          wcount, first_cnt, viol, stall_cnt;
  logic [31:0] cap_a, cap_b, cap_c, first_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (cur_mult) return orig[cur_vs2][k] ^ orig[cur_vs1][k] ^ orig[cur_vd][k];
    return orig[cur_vs2][k] + orig[cur_vs1][k];
  endfunction

  task automatic snapshot();
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < NW; w++) orig[r][w] = mem[r][w];
  endtask

  task automatic begin_op(input logic [VLW-1:0] vl, input logic [2:0] vsew, input logic [4:0] vs1,
                          input logic [4:0] vs2, input logic [4:0] vd, input logic mult,
                          input int stall, input logic noise, input int nw, input logic [3:0] lwbe);
    cur_vs1 = vs1; cur_vs2 = vs2; cur_vd = vd; cur_mult = mult; cur_vsew = vsew;
    cur_stall = stall; cur_noise = noise; cur_nw = nw; cur_lwbe = lwbe;
    cur_alu = mult ? ALU_ADD : ALU_XOR;
    cur_md  = mult ? MD_OP_MULH : MD_OP_MULL;
    wcount = 0; first_cnt = 0; viol = 0; stall_cnt = 0; first_wdata = '0;
    snapshot();
    req_vl = vl; req_vsew = vsew; req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    req_mult = mult; req_alu_op = cur_alu; req_md_op = cur_md;
    ex_valid = noise; ex_result = 32'hDEAD_BEEF;
    chk("ready_before_accept", {31'b0, req_ready_o}, 32'd1);
    req_valid = 1'b1;
  endtask

  // Called at a negedge: checks any write strobe of this cycle and updates the VRF model.
  task automatic mon_step();
    int k;
    logic [3:0] ewbe;
    if (vrf_we_o) begin
      k = wcount;
      ewbe = (k == cur_nw - 1) ? cur_lwbe : 4'hF;
      if (k == 0) first_wdata = vrf_wdata_o;
      chk("wr_reg", {27'b0, vrf_wreg_o}, {27'b0, cur_vd});
      chk("wr_word", {29'b0, vrf_wword_o}, k);
      chk("wr_be", {28'b0, vrf_wbe_o}, {28'b0, ewbe});
      chk("wr_data", vrf_wdata_o, exp_word(k % NW));
      for (int b = 0; b < 4; b++)
        if (vrf_wbe_o[b]) mem[vrf_wreg_o][vrf_wword_o][8*b +: 8] = vrf_wdata_o[8*b +: 8];
      wcount++;
    end
  endtask

  // Called at a negedge: EX stub response for the next active edge plus EXEC invariants.
  task automatic ex_step();
    if (ex_vec_instr_o) begin
      if (stall_cnt == 0) begin
        first_cnt++;
        if (!ex_instr_first_cycle_o) viol++;
        cap_a = ex_operand_a_o; cap_b = ex_operand_b_o; cap_c = ex_operand_c_o;
      end else begin
        if (ex_instr_first_cycle_o) viol++;
        if (ex_operand_a_o !== cap_a || ex_operand_b_o !== cap_b || ex_operand_c_o !== cap_c) viol++;
      end
      if (ex_mult_en_o !== cur_mult || ex_mult_sel_o !== cur_mult) viol++;
      if (ex_vsew_o !== cur_vsew || ex_alu_operator_o !== cur_alu || ex_md_op_o !== cur_md) viol++;
      ex_valid  = (stall_cnt == cur_stall);
      ex_result = ex_mult_sel_o ? (ex_operand_a_o ^ ex_operand_b_o ^ ex_operand_c_o)
                                : (ex_operand_a_o + ex_operand_b_o);
      stall_cnt++;
    end else begin
      if (ex_mult_en_o || ex_instr_first_cycle_o) viol++;
      stall_cnt = 0;
      ex_valid  = cur_noise;
      ex_result = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_vec(input int v);
    int cyc;
    bit got;
    vec_t t;
    t = tbl[v];
    begin_op(t.vl, t.vsew, t.vs1, t.vs2, t.vd, t.mult, t.stall, t.noise, t.nw, t.lwbe);
    cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      mon_step();
      if (done_o) begin
        got = 1;
        chk($sformatf("v%0d_latency", v), cyc, t.lat);
        chk($sformatf("v%0d_err", v), {31'b0, err_o}, {31'b0, t.err});
      end
      ex_step();
    end
    if (!got) chk($sformatf("v%0d_done_timeout", v), 32'd0, 32'd1);
    ex_valid = 1'b0;
    chk($sformatf("v%0d_writes", v), wcount, t.nw);
    chk($sformatf("v%0d_first_cycles", v), first_cnt, t.nw);
    chk($sformatf("v%0d_ex_violations", v), viol, 0);
    if (v == 0) chk("v0_sum_word", first_wdata, 32'h1112_1314);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", v), {31'b0, done_o}, 32'd0);
    chk($sformatf("v%0d_ready_after", v), {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    int n_we, n_done;
    tbl[0]  = '{6'd4,  3'd0, 5'd1,  5'd2,  5'd3,  1'b0, 0, 1'b0, 1, 4'hF, 1'b0, 4};
    tbl[1]  = '{6'd3,  3'd1, 5'd4,  5'd5,  5'd6,  1'b0, 0, 1'b0, 2, 4'h3, 1'b0, 7};
    tbl[2]  = '{6'd0,  3'd0, 5'd1,  5'd2,  5'd3,  1'b0, 0, 1'b0, 0, 4'hF, 1'b0, 1};
    tbl[3]  = '{6'd5,  3'd3, 5'd1,  5'd2,  5'd3,  1'b0, 0, 1'b0, 0, 4'hF, 1'b1, 1};
    tbl[4]  = '{6'd0,  3'd3, 5'd1,  5'd2,  5'd3,  1'b0, 0, 1'b0, 0, 4'hF, 1'b1, 1};
    tbl[5]  = '{6'd8,  3'd2, 5'd7,  5'd8,  5'd12, 1'b1, 5, 1'b0, 8, 4'hF, 1'b0, 65};
    tbl[6]  = '{6'd5,  3'd0, 5'd13, 5'd14, 5'd13, 1'b0, 0, 1'b1, 2, 4'h1, 1'b0, 7};
    tbl[7]  = '{6'd40, 3'd0, 5'd15, 5'd16, 5'd17, 1'b0, 0, 1'b0, 8, 4'hF, 1'b0, 25};
    tbl[8]  = '{6'd7,  3'd1, 5'd18, 5'd19, 5'd20, 1'b1, 2, 1'b0, 4, 4'h3, 1'b0, 21};
    tbl[9]  = '{6'd3,  3'd2, 5'd21, 5'd22, 5'd22, 1'b0, 0, 1'b1, 3, 4'hF, 1'b0, 10};
    tbl[10] = '{6'd2,  3'd7, 5'd1,  5'd2,  5'd3,  1'b0, 0, 1'b0, 0, 4'hF, 1'b1, 1};

    for (int r = 0; r < 32; r++)
      for (int w = 0; w < NW; w++) mem[r][w] = 32'(r) * 32'h0100_0193 + 32'(w) * 32'h0001_0101 + 32'h1234;
    mem[1][0] = 32'h0102_0304;
    mem[2][0] = 32'h1010_1010;

    rst_ni = 1'b0; req_valid = 1'b0; req_vl = '0; req_vsew = '0;
    req_vs1 = '0; req_vs2 = '0; req_vd = '0; req_alu_op = ALU_ADD; req_mult = 1'b0;
    req_md_op = MD_OP_MULL; ex_valid = 1'b0; ex_result = '0;
    cur_noise = 1'b0; cur_stall = 0; cur_mult = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_done_err", {30'b0, done_o, err_o}, 32'd0);
    chk("rst_we_be", {27'b0, vrf_we_o, vrf_wbe_o}, 32'd0);
    chk("rst_ex_ctl", {29'b0, ex_vec_instr_o, ex_mult_en_o, ex_instr_first_cycle_o}, 32'd0);
    chk("rst_rword", {29'b0, vrf_rword_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 11; v++) run_vec(v);

    // Reset during the first EXEC cycle of word 2 of an 8-word op.
    begin_op(6'd8, 3'd2, 5'd10, 5'd11, 5'd9, 1'b0, 3, 1'b0, 8, 4'hF);
    for (int c = 0; c < 200 && first_cnt < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mon_step();
      ex_step();
    end
    chk("rstop_reached_word2", first_cnt, 3);
    chk("rstop_writes_before", wcount, 2);
    rst_ni = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    chk("rstop_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rstop_idle_outs", {29'b0, ex_vec_instr_o, vrf_we_o, done_o}, 32'd0);
    rst_ni = 1'b1;
    n_we = 0; n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (vrf_we_o) n_we++;
      if (done_o) n_done++;
    end
    chk("rstop_no_we", n_we, 0);
    chk("rstop_no_done", n_done, 0);
    run_vec(1);

`ifdef VCVE2_VEC_SEQ_KILL_EN
    // Kill in WRITE of word 0: no write, IDLE next cycle, then a fresh op runs normally.
    begin_op(6'd4, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 0, 1'b0, 1, 4'hF);
    @(negedge clk);
    req_valid = 1'b0;
    ex_step();
    @(negedge clk);
    chk("kill_in_exec", {31'b0, ex_vec_instr_o}, 32'd1);
    ex_step();
    @(posedge clk);
    #1 kill_i = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("kill_no_we", {31'b0, vrf_we_o}, 32'd0);
    chk("kill_no_done", {31'b0, done_o}, 32'd0);
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    chk("kill_idle_ready", {31'b0, req_ready_o}, 32'd1);
    chk("kill_no_done_after", {31'b0, done_o}, 32'd0);
    run_vec(0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
